// File: rtl/reset_ctrl.sv
// Reset sequencer for the 50 MHz system domain.
// Combines PLL lock, a debounced reset button, debug-module NDM requests and
// software requests into two stretched, registered resets. It also keeps a
// sticky reset-reason register on a minimal pipelined Wishbone slave.
module reset_ctrl #(
  parameter int RST_STRETCH_CYCLES = 16,
  parameter int DEBOUNCE_CYCLES    = 1000,
  parameter int SYNC_STAGES        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked_i,
  input  logic        ext_rst_ni,
  input  logic        ndm_req_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic        wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        ndm_reset_o,
  output logic        dm_reset_o
);

  localparam int CNT_W = (RST_STRETCH_CYCLES > 2) ? $clog2(RST_STRETCH_CYCLES) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_STRETCH_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STRETCH,
    S_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   locked_s;
  logic                   btn_s;

  logic                   btn_acc_q;
  logic [DEB_W-1:0]       deb_cnt_q;
  logic                   btn_diff;
  logic                   deb_done;
  logic                   press;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   full_q, full_d;
  logic [4:0]             reason_q, reason_d;
  logic [4:0]             rsn_set;
  logic [4:0]             rsn_clr;
  logic                   ndm_reset_q;
  logic                   dm_reset_q;

  logic                   req;
  logic                   wr_reason;
  logic                   wr_ctrl;
  logic                   ctrl_ndm;
  logic                   ctrl_full;
  logic                   ack_q;
  logic [31:0]            dat_q;
  logic                   unused_dat;

  assign locked_s   = lock_sync_q[SYNC_STAGES-1];
  assign btn_s      = btn_sync_q[SYNC_STAGES-1];

  assign req        = wb_cyc_i & wb_stb_i;
  assign wr_reason  = req & wb_we_i & ~wb_adr_i;
  assign wr_ctrl    = req & wb_we_i & wb_adr_i;
  assign ctrl_ndm   = wr_ctrl & wb_dat_i[0];
  assign ctrl_full  = wr_ctrl & wb_dat_i[1];
  assign rsn_clr    = wr_reason ? wb_dat_i[4:0] : 5'd0;
  assign unused_dat = ^wb_dat_i[31:5];

  // Bring the asynchronous lock and button levels into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], ext_rst_ni};
    end
  end

  // A press fires once, on the sample that completes a full run of pressed samples.
  always_comb begin
    btn_diff = (btn_s != btn_acc_q);
    deb_done = btn_diff && (deb_cnt_q == DEB_LAST);
    press    = deb_done && btn_acc_q;
  end

  // Debouncer: count consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_acc_q <= 1'b1;
      deb_cnt_q <= '0;
    end else if (!btn_diff) begin
      deb_cnt_q <= '0;
    end else if (deb_done) begin
      btn_acc_q <= btn_s;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  // Next-state logic: one event per cycle, in priority order, in RUN and STRETCH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    rsn_set = 5'd0;
    case (state_q)
      S_RESET: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = S_STRETCH;
      end
      S_STRETCH, S_RUN: begin
        if (!locked_s) begin
          state_d    = S_WAIT_LOCK;
          cnt_d      = '0;
          full_d     = 1'b1;
          rsn_set[1] = 1'b1;
        end else if (press) begin
          state_d    = S_STRETCH;
          cnt_d      = '0;
          full_d     = 1'b1;
          rsn_set[2] = 1'b1;
        end else if (ctrl_full) begin
          state_d    = S_STRETCH;
          cnt_d      = '0;
          full_d     = 1'b1;
          rsn_set[4] = 1'b1;
        end else if (ndm_req_i) begin
          state_d    = S_STRETCH;
          cnt_d      = '0;
          rsn_set[3] = 1'b1;
        end else if (ctrl_ndm) begin
          state_d    = S_STRETCH;
          cnt_d      = '0;
          rsn_set[4] = 1'b1;
        end else if (state_q == S_STRETCH) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            full_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_RESET;
    endcase
    // A set in the same cycle as a write-1-to-clear wins.
    reason_d = (reason_q & ~rsn_clr) | rsn_set;
  end

  // Sequencer state, reason register and registered reset outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      full_q      <= 1'b1;
      reason_q    <= 5'h01;
      ndm_reset_q <= 1'b1;
      dm_reset_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      reason_q    <= reason_d;
      ndm_reset_q <= (state_d != S_RUN);
      dm_reset_q  <= (state_d != S_RUN) && full_d;
    end
  end

  // Bus responder: every strobe is acked the next cycle; CTRL reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wb_we_i && !wb_adr_i) ? {27'd0, reason_q} : 32'd0;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign wb_stall_o  = 1'b0;
  assign ndm_reset_o = ndm_reset_q;
  assign dm_reset_o  = dm_reset_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed scenarios plus a randomized phase, all
// compared cycle by cycle against a countdown-style behavioural model.
module tb_reset_ctrl;

  localparam int STRETCH = 16;
  localparam int DEB     = 8;
  localparam int SYNC    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked_i;
  logic        ext_rst_ni;
  logic        ndm_req_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic        ndm_reset_o;
  logic        dm_reset_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          lk_q[$];
  bit          bt_q[$];
  bit          m_prev;
  int          m_run;
  bit          m_acc;
  int          m_hold;
  bit          m_want;
  int          m_left;
  bit          m_full;
  logic [4:0]  m_reason;
  bit          exp_ack;
  logic [31:0] exp_dat;
  bit          exp_ndm;
  bit          exp_dm;

  reset_ctrl #(
    .RST_STRETCH_CYCLES(STRETCH),
    .DEBOUNCE_CYCLES   (DEB),
    .SYNC_STAGES       (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked_i(pll_locked_i),
    .ext_rst_ni  (ext_rst_ni),
    .ndm_req_i   (ndm_req_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_stall_o  (wb_stall_o),
    .ndm_reset_o (ndm_reset_o),
    .dm_reset_o  (dm_reset_o)
  );

  initial forever #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, step the model with the inputs present at that edge,
  // then compare all outputs 1 time unit after the edge.
  task automatic tick();
    bit          c_rst = rst;
    bit          c_lk  = pll_locked_i;
    bit          c_bt  = ext_rst_ni;
    bit          c_ndm = ndm_req_i;
    bit          c_req = wb_cyc_i & wb_stb_i;
    bit          c_we  = wb_we_i;
    bit          c_adr = wb_adr_i;
    logic [31:0] c_dat = wb_dat_i;
    bit          lks, bts, press, c_full, c_nreq;
    logic [4:0]  set_b, clr_b;
    @(posedge clk);
    if (c_rst) begin
      lk_q = '{1'b0, 1'b0};
      bt_q = '{1'b1, 1'b1};
      m_prev = 1'b1; m_run = 0; m_acc = 1'b1;
      m_hold = 1; m_want = 1'b1; m_left = 0; m_full = 1'b1;
      m_reason = 5'h01;
      exp_ack = 1'b0; exp_dat = 32'd0;
    end else begin
      lks = lk_q.pop_front(); lk_q.push_back(c_lk);
      bts = bt_q.pop_front(); bt_q.push_back(c_bt);
      // Accept a level after DEB equal samples in a row.
      if (bts == m_prev) m_run++; else m_run = 1;
      m_prev = bts;
      press = 1'b0;
      if (m_run >= DEB && bts != m_acc) begin
        m_acc = bts;
        press = (bts == 1'b0);
      end
      exp_ack = c_req;
      exp_dat = (c_req && !c_we && !c_adr) ? {27'd0, m_reason} : 32'd0;
      c_full = c_req && c_we && c_adr && c_dat[1];
      c_nreq = c_req && c_we && c_adr && c_dat[0];
      clr_b  = (c_req && c_we && !c_adr) ? c_dat[4:0] : 5'd0;
      set_b  = 5'd0;
      if (m_hold > 0) begin
        m_hold--;
      end else if (m_want) begin
        if (lks) begin m_want = 1'b0; m_left = STRETCH; end
      end else begin
        if (!lks) begin
          m_want = 1'b1; m_left = 0; m_full = 1'b1; set_b[1] = 1'b1;
        end else if (press) begin
          m_left = STRETCH; m_full = 1'b1; set_b[2] = 1'b1;
        end else if (c_full) begin
          m_left = STRETCH; m_full = 1'b1; set_b[4] = 1'b1;
        end else if (c_ndm) begin
          m_left = STRETCH; set_b[3] = 1'b1;
        end else if (c_nreq) begin
          m_left = STRETCH; set_b[4] = 1'b1;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_full = 1'b0;
        end
      end
      m_reason = (m_reason & ~clr_b) | set_b;
    end
    exp_ndm = (m_hold > 0) || m_want || (m_left > 0);
    exp_dm  = exp_ndm && m_full;
    #1;
    check("ndm_reset", 32'(ndm_reset_o), 32'(exp_ndm));
    check("dm_reset",  32'(dm_reset_o),  32'(exp_dm));
    check("wb_ack",    32'(wb_ack_o),    32'(exp_ack));
    check("wb_dat",    wb_dat_o,         exp_dat);
  endtask

  task automatic wb_read(input bit adr, output logic [31:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr; wb_dat_i = 32'd0;
    tick();
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic wb_write(input bit adr, input logic [31:0] v);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = v;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 32'd0;
  endtask

  initial begin
    logic [31:0] rd;
    int cnt;
    int hi;
    int rises;
    bit prev;
    bit dm_seen;
    int unsigned r;

    rst = 1'b1; pll_locked_i = 1'b0; ext_rst_ni = 1'b1; ndm_req_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_dat_i = 32'd0;

    // Power-on: rst for 5 cycles, lock 10 cycles after rst falls.
    repeat (5) tick();
    check("por_ndm_during_rst", 32'(ndm_reset_o), 32'd1);
    check("por_dm_during_rst",  32'(dm_reset_o),  32'd1);
    rst = 1'b0;
    repeat (9) tick();
    pll_locked_i = 1'b1;
    tick();
    cnt = 0;
    while (ndm_reset_o && cnt < 200) begin tick(); cnt++; end
    check("por_release_delay", 32'(cnt), 32'(SYNC + STRETCH));
    check("por_dm_released", 32'(dm_reset_o), 32'd0);
    wb_read(1'b0, rd);
    check("por_reason", rd, 32'h01);

    // Single-cycle NDM request.
    ndm_req_i = 1'b1;
    tick();
    ndm_req_i = 1'b0;
    cnt = 0; dm_seen = 1'b0;
    while (ndm_reset_o && cnt < 200) begin
      if (dm_reset_o) dm_seen = 1'b1;
      tick(); cnt++;
    end
    check("ndm_len", 32'(cnt), 32'(STRETCH));
    check("ndm_no_dm", 32'(dm_seen), 32'd0);
    wb_read(1'b0, rd);
    check("ndm_reason", rd, 32'h09);
    wb_write(1'b0, 32'h1F);
    wb_read(1'b0, rd);
    check("reason_w1c", rd, 32'h00);

    // Bouncy button, then held low.
    for (int i = 0; i < 10; i++) begin
      ext_rst_ni = ~ext_rst_ni;
      repeat (3) tick();
    end
    ext_rst_ni = 1'b0;
    rises = 0; hi = 0; prev = dm_reset_o;
    repeat (40) begin
      tick();
      if (dm_reset_o && !prev) rises++;
      if (dm_reset_o) hi++;
      prev = dm_reset_o;
    end
    check("btn_events", 32'(rises), 32'd1);
    check("btn_len", 32'(hi), 32'(STRETCH));
    ext_rst_ni = 1'b1;
    repeat (20) tick();
    wb_read(1'b0, rd);
    check("btn_reason", rd, 32'h04);

    // PLL unlock during the stretch of an NDM reset.
    ndm_req_i = 1'b1;
    tick();
    ndm_req_i = 1'b0;
    repeat (3) tick();
    pll_locked_i = 1'b0;
    dm_seen = 1'b0;
    repeat (20) begin tick(); if (dm_reset_o) dm_seen = 1'b1; end
    check("unlock_dm", 32'(dm_seen), 32'd1);
    pll_locked_i = 1'b1;
    tick();
    cnt = 0;
    while (ndm_reset_o && cnt < 200) begin tick(); cnt++; end
    check("relock_delay", 32'(cnt), 32'(SYNC + STRETCH));
    wb_read(1'b0, rd);
    check("unlock_reason", rd, 32'h0E);
    wb_write(1'b0, 32'h1F);

    // Software reset with both CTRL bits: full reset wins.
    wb_write(1'b1, 32'h3);
    check("sw_ack", 32'(wb_ack_o), 32'd1);
    cnt = 0;
    while (dm_reset_o && cnt < 200) begin tick(); cnt++; end
    check("sw_full_len", 32'(cnt), 32'(STRETCH));
    wb_read(1'b1, rd);
    check("ctrl_read", rd, 32'h0);
    wb_read(1'b0, rd);
    check("sw_reason", rd, 32'h10);
    wb_write(1'b0, 32'h1F);

    // Held NDM request with a same-cycle clear of its reason bit.
    ndm_req_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 1'b0; wb_dat_i = 32'h08;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 32'd0;
    repeat (39) tick();
    check("hold_ndm_high", 32'(ndm_reset_o), 32'd1);
    ndm_req_i = 1'b0;
    cnt = 0;
    while (ndm_reset_o && cnt < 200) begin tick(); cnt++; end
    check("hold_release", 32'(cnt), 32'(STRETCH));
    wb_read(1'b0, rd);
    check("hold_reason", rd, 32'h08);

    // Randomized traffic, including a mid-run rst and lock glitches.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      ndm_req_i = (r < 6);
      if (r >= 10 && r < 35) begin
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_we_i  = 1'($urandom_range(0, 1));
        wb_adr_i = 1'($urandom_range(0, 1));
        wb_dat_i = $urandom();
      end else begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 32'd0;
      end
      if (pll_locked_i && $urandom_range(0, 149) == 0) pll_locked_i = 1'b0;
      else if (!pll_locked_i && $urandom_range(0, 9) == 0) pll_locked_i = 1'b1;
      rst = (i == 300 || i == 301);
      tick();
    end
    rst = 1'b0; ndm_req_i = 1'b0; pll_locked_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 32'd0;
    repeat (30) tick();
    check("final_run", 32'(ndm_reset_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
